// File: rtl/mode_seq_pkg.sv
// Shared types and sizes for the four-mode LED sequencer.
package mode_seq_pkg;

    localparam int N_MODES = 4;
    localparam int LED_W   = 8;
    localparam int MODE_W  = 2;

    typedef enum logic [1:0] {
        RESTART = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2
    } seq_state_e;

    function automatic logic [N_MODES-1:0] mode_onehot(input logic [MODE_W-1:0] m);
        logic [N_MODES-1:0] oh;
        oh    = '0;
        oh[m] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Pattern-tick prescaler: counts 0..TICK_DIV-1, tc flags the terminal count.
// clr restarts from zero, hold freezes the count and suppresses tc.
module tick_prescaler #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic hold,
    output logic tc
);

    localparam int               CNT_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (!hold) begin
            cnt_d = (cnt_q == TC_VAL) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == TC_VAL) && !hold && !clr;

endmodule

// File: rtl/mode_sequencer.sv
// Routes tick/pause/restart to one of four LED mode processors and muxes its LEDs.
// Define MODE_SEQ_AUTO_CYCLE_EN to auto-advance the mode after AUTO_TICKS ticks.
//
// state   | meaning
// RESTART | one cycle: restart pulse to the active processor, prescaler from zero
// RUN     | prescaler running, ticks routed to the active processor
// PAUSE   | prescaler held, no ticks, active processor sees pause
module mode_sequencer
    import mode_seq_pkg::*;
#(
    parameter int TICK_DIV   = 25_000_000,
    parameter int AUTO_TICKS = 64
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     btn_mode,
    input  logic                     btn_pause,
    input  logic [N_MODES*LED_W-1:0] mode_leds,
    output logic [N_MODES-1:0]       mode_tick,
    output logic [N_MODES-1:0]       mode_pause,
    output logic [N_MODES-1:0]       mode_rst,
    output logic [LED_W-1:0]         leds,
    output logic [MODE_W-1:0]        mode,
    output logic                     paused
);

    if (TICK_DIV < 2 || AUTO_TICKS < 1) begin : g_param_check
        $error("mode_sequencer: TICK_DIV must be >= 2 and AUTO_TICKS >= 1");
    end

    seq_state_e         state_q, state_d;
    logic [MODE_W-1:0]  mode_q, mode_d;
    logic [N_MODES-1:0] tick_q, tick_d;
    logic [N_MODES-1:0] pause_q, pause_d;
    logic [N_MODES-1:0] rst_q, rst_d;
    logic [LED_W-1:0]   leds_q, leds_d;
    logic               paused_q, paused_d;
    logic               tc;
    logic               restart_entry;
    logic               auto_adv;
    logic               advance;

    assign advance = btn_mode || auto_adv;

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        case (state_q)
            RESTART: state_d = RUN;
            RUN: begin
                if (advance) begin
                    state_d = RESTART;
                    mode_d  = mode_q + 1'b1;
                end else if (btn_pause) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (advance) begin
                    state_d = RESTART;
                    mode_d  = mode_q + 1'b1;
                end else if (btn_pause) begin
                    state_d = RUN;
                end
            end
            default: state_d = RESTART;
        endcase
    end

    // Reset parks in RESTART with rst_q clear, so that first RESTART still fires its pulse.
    assign restart_entry = (state_d == RESTART) || (state_q == RESTART && rst_q == '0);

    assign rst_d    = restart_entry ? mode_onehot(mode_d) : '0;
    assign tick_d   = (tc && state_q == RUN && state_d == RUN) ? mode_onehot(mode_q) : '0;
    assign pause_d  = (state_d == PAUSE) ? '1 : ~mode_onehot(mode_d);
    assign paused_d = (state_d == PAUSE);
    assign leds_d   = mode_leds[int'(mode_q)*LED_W +: LED_W];

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (restart_entry),
        .hold  (state_q == PAUSE),
        .tc    (tc)
    );

`ifdef MODE_SEQ_AUTO_CYCLE_EN
    localparam int ATC_W = $clog2(AUTO_TICKS + 1);

    logic [ATC_W-1:0] atc_q, atc_d;

    assign auto_adv = (state_q == RUN) && (atc_q == ATC_W'(AUTO_TICKS));

    always_comb begin
        atc_d = atc_q;
        if (state_q == RESTART) begin
            atc_d = '0;
        end else if (tick_d != '0) begin
            atc_d = atc_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            atc_q <= '0;
        end else begin
            atc_q <= atc_d;
        end
    end
`else
    assign auto_adv = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= RESTART;
            mode_q   <= '0;
            tick_q   <= '0;
            pause_q  <= '1;
            rst_q    <= '0;
            leds_q   <= '0;
            paused_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            tick_q   <= tick_d;
            pause_q  <= pause_d;
            rst_q    <= rst_d;
            leds_q   <= leds_d;
            paused_q <= paused_d;
        end
    end

    assign mode_tick  = tick_q;
    assign mode_pause = pause_q;
    assign mode_rst   = rst_q;
    assign leds       = leds_q;
    assign mode       = mode_q;
    assign paused     = paused_q;

endmodule

// File: tb/tb_mode_sequencer.sv
// Directed bench for mode_sequencer with TICK_DIV=4, AUTO_TICKS=3.
// Build with MODE_SEQ_AUTO_CYCLE_EN to exercise the auto-advance scenario instead.
module tb_mode_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        btn_mode;
    logic        btn_pause;
    logic [31:0] mode_leds;
    logic [3:0]  mode_tick;
    logic [3:0]  mode_pause;
    logic [3:0]  mode_rst;
    logic [7:0]  leds;
    logic [1:0]  mode;
    logic        paused;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0] exp_mode [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] exp_leds [4] = '{8'hBB, 8'hCC, 8'hDD, 8'hAA};
    logic [3:0] exp_rst  [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};

    mode_sequencer #(
        .TICK_DIV   (4),
        .AUTO_TICKS (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_mode   (btn_mode),
        .btn_pause  (btn_pause),
        .mode_leds  (mode_leds),
        .mode_tick  (mode_tick),
        .mode_pause (mode_pause),
        .mode_rst   (mode_rst),
        .leds       (leds),
        .mode       (mode),
        .paused     (paused)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; the buttons are sampled by the next posedge.
    task automatic pulse(input logic bm, input logic bp);
        btn_mode  = bm;
        btn_pause = bp;
        @(negedge clk);
        btn_mode  = 1'b0;
        btn_pause = 1'b0;
    endtask

    task automatic wait_tick(input int max, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (mode_tick == 4'b0000 && n < max);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int nt;
        reset     = 1'b0;
        btn_mode  = 1'b0;
        btn_pause = 1'b0;
        mode_leds = 32'hDDCC_BBAA;
        repeat (3) @(negedge clk);

        check("rst_mode",   mode,       2'd0);
        check("rst_leds",   leds,       8'h00);
        check("rst_tick",   mode_tick,  4'b0000);
        check("rst_rstv",   mode_rst,   4'b0000);
        check("rst_pausev", mode_pause, 4'b1111);
        check("rst_paused", paused,     1'b0);

        reset = 1'b1;
`ifdef MODE_SEQ_AUTO_CYCLE_EN
        nt = 0;
        for (int i = 1; i <= 14; i++) begin
            @(negedge clk);
            if (mode_tick != 4'b0000) nt++;
            if (i == 13) check("auto_hold_mode", mode, 2'd0);
        end
        check("auto_ticks",    nt,       3);
        check("auto_mode",     mode,     2'd1);
        check("auto_rstpulse", mode_rst, 4'b0010);

        @(negedge clk);
        pulse(1'b0, 1'b1);
        check("auto_paused", paused, 1'b1);
        repeat (50) @(negedge clk);
        check("auto_pause_mode", mode, 2'd1);

        pulse(1'b0, 1'b1);
        check("auto_resumed", paused, 1'b0);
        n = 0;
        while (mode == 2'd1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("auto_resume_mode", mode, 2'd2);
        check("auto_resume_lat",  n,    11);
`else
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            check("rel_rst",   mode_rst,   (i == 1) ? 4'b0001 : 4'b0000);
            check("rel_tick",  mode_tick,  (i >= 5 && (i - 5) % 4 == 0) ? 4'b0001 : 4'b0000);
            check("rel_pause", mode_pause, 4'b1110);
        end

        for (int k = 0; k < 4; k++) begin
            pulse(1'b1, 1'b0);
            check("adv_mode",    mode,     exp_mode[k]);
            check("adv_rst",     mode_rst, exp_rst[k]);
            @(negedge clk);
            check("adv_leds",    leds,     exp_leds[k]);
            check("adv_rst_clr", mode_rst, 4'b0000);
        end

        wait_tick(10, n);
        check("pre_tick", mode_tick, 4'b0001);
        @(negedge clk);
        pulse(1'b0, 1'b1);
        check("pause_on",  paused,     1'b1);
        check("pause_vec", mode_pause, 4'b1111);
        nt = 0;
        repeat (20) begin
            @(negedge clk);
            if (mode_tick != 4'b0000) nt++;
        end
        check("pause_ticks", nt,     0);
        check("pause_held",  paused, 1'b1);

        pulse(1'b0, 1'b1);
        check("resume",     paused,     1'b0);
        check("resume_vec", mode_pause, 4'b1110);
        wait_tick(10, n);
        check("resume_lat",  n + 1,     3);
        check("resume_tick", mode_tick, 4'b0001);

        pulse(1'b1, 1'b1);
        check("both_mode",   mode,     2'd1);
        check("both_rst",    mode_rst, 4'b0010);
        check("both_paused", paused,   1'b0);
        @(negedge clk);
        check("both_rst_once", mode_rst,   4'b0000);
        check("both_run",      paused,     1'b0);
        check("both_vec",      mode_pause, 4'b1101);

        pulse(1'b1, 1'b0);
        check("m2_mode", mode, 2'd2);
        @(negedge clk);
        pulse(1'b0, 1'b1);
        check("m2_paused", paused,     1'b1);
        check("m2_vec",    mode_pause, 4'b1111);
        repeat (2) @(negedge clk);
        mode_leds = 32'hDD5A_BBAA;
        @(negedge clk);
        check("pause_leds", leds, 8'h5A);

        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_mode",   mode,       2'd0);
        check("mid_rst_paused", paused,     1'b0);
        check("mid_rst_leds",   leds,       8'h00);
        check("mid_rst_vec",    mode_pause, 4'b1111);
        check("mid_rst_tick",   mode_tick,  4'b0000);

        reset     = 1'b1;
        mode_leds = 32'hDDCC_BBAA;
        @(negedge clk);
        check("rerel_rst",  mode_rst,   4'b0001);
        check("rerel_vec",  mode_pause, 4'b1110);
        check("rerel_leds", leds,       8'hAA);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mode_sequencer.md
# mode_sequencer

Top-level controller for the four-mode LED pattern design with pause. Generates the shared pattern tick from the system clock and routes tick, pause and a per-mode restart to exactly one of four mode processors at a time. Advances the active mode on a button pulse and toggles pause on another. Muxes the active processor's 8-bit LED bus to the board LEDs.

## Interface

- `TICK_DIV`, default 25_000_000: clock cycles per pattern tick; must be ≥ 2.
- `AUTO_TICKS`, default 64: ticks spent in one mode before auto-advance. Used only with `MODE_SEQ_AUTO_CYCLE_EN`.
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-low reset (`reset == 0` resets).
- `btn_mode` in 1: one-cycle pulse, already debounced and synchronised; advances the mode.
- `btn_pause` in 1: one-cycle pulse, already debounced; toggles pause.
- `mode_leds` in 32: LED buses of processors 3..0, as {m3, m2, m1, m0}, 8 bits each.
- `mode_tick` out 4: one-hot tick pulse to the active processor.
- `mode_pause` out 4: pause level per processor.
- `mode_rst` out 4: active-high, one-cycle restart pulse per processor.
- `leds` out 8: board LEDs.
- `mode` out 2: index of the active mode.
- `paused` out 1: high while in PAUSE.

## Operation

- States are RESTART, RUN and PAUSE.
- Reset: `mode`=0, state RESTART, prescaler=0, `leds`=0, `mode_tick`=0, `mode_rst`=0, `mode_pause`=4'b1111, `paused`=0.
- RESTART lasts exactly one cycle:
  - `mode_rst[mode]`=1; prescaler cleared.
  - Next state is RUN.
  - Buttons are ignored in this state.
- RUN:
  - The prescaler counts 0..TICK_DIV-1 and wraps.
  - At terminal count, `mode_tick[mode]`=1 for one cycle.
  - `btn_mode` sets `mode` to (mode+1) mod 4; 3 wraps to 0. Next state is RESTART.
  - `btn_pause` moves to PAUSE.
- PAUSE:
  - The prescaler holds its value; there are no ticks.
  - `btn_pause` returns to RUN, and the prescaler resumes from the held count.
  - `btn_mode` advances the mode and goes to RESTART, which clears the pause.
- Simultaneous `btn_mode` and `btn_pause`: `btn_mode` wins and `btn_pause` is dropped.
- `mode_pause`:
  - Inactive processors are always 1.
  - The active processor is 1 only in PAUSE.
- `mode_tick` and `mode_rst` are never asserted for inactive processors.
- `leds` is a registered copy of `mode_leds[8*mode +: 8]`, updated every cycle, including in PAUSE.
- Reset asserted mid-operation overrides every state on that edge.

## Timing

- All outputs are registered.
- Tick: the prescaler reaches TICK_DIV-1 at edge n, and `mode_tick` is high during cycle n+1.
- Spacing:
  - Consecutive ticks are exactly TICK_DIV cycles apart.
  - The first tick after RESTART comes TICK_DIV cycles after the `mode_rst` cycle.
- `btn_mode` sampled at edge n:
  - `mode` is new and `mode_rst` is high in cycle n+1.
  - State is RUN in cycle n+2.
- `btn_pause` sampled at edge n: `paused` and `mode_pause[mode]` change in cycle n+1.
- `leds` lags `mode_leds` by one cycle. After a mode change it shows the new processor from cycle n+2.

## Configuration

- `MODE_SEQ_AUTO_CYCLE_EN` defined:
  - A tick counter counts ticks issued in RUN.
  - On reaching AUTO_TICKS it behaves exactly like a `btn_mode` pulse.
  - The counter clears in RESTART and holds in PAUSE.
  - A real `btn_mode` in the same cycle causes a single advance, not two.
- Not defined: the tick counter is absent, and `mode` changes only on `btn_mode`.

## Structure

- Package `mode_seq_pkg` holds:
  - the state enum (RESTART, RUN, PAUSE);
  - `N_MODES`=4;
  - `LED_W`=8;
  - the mode index width (2).
- Sub-module `tick_prescaler`:
  - inputs `clk`, `reset`, `clr`, `hold`;
  - output `tc`, the terminal-count pulse;
  - parameter `TICK_DIV`.

## Test plan

Bench uses TICK_DIV=4 and AUTO_TICKS=3.

- Reset release, no buttons:
  - `mode_rst`=4'b0001 for one cycle.
  - Then `mode_tick`=4'b0001 every 4 cycles.
  - `mode_pause`=4'b1110.
- `mode_leds`=32'hDD_CC_BB_AA, `btn_mode` pulsed 4 times:
  - `mode` goes 1, 2, 3, 0.
  - `leds` goes 8'hBB, 8'hCC, 8'hDD, 8'hAA.
  - `mode_rst` goes 0010, 0100, 1000, 0001.
- `btn_pause` one cycle after a tick:
  - `paused`=1 and no ticks for 20 cycles.
  - Second `btn_pause`: the next tick arrives 3 cycles after resume, because the prescaler held.
- `btn_mode` and `btn_pause` in the same cycle while in RUN: `mode` increments, `paused` stays 0, `mode_rst` pulses once.
- `reset` driven low mid-PAUSE with `mode`=2: next cycle `mode`=0, `paused`=0, `leds`=0, `mode_pause`=4'b1111.
- With `MODE_SEQ_AUTO_CYCLE_EN`:
  - After 3 ticks in mode 0, `mode`=1 with no button.
  - Pausing for 50 cycles does not advance the mode.
